// File: rtl/stp8to128.sv
// stp8to128: gathers 16 input bytes into one 128-bit block, first byte in the
// MSB position, and hands finished blocks downstream through a one-entry
// holding register so the accumulator can keep filling while a block waits.
module stp8to128 (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  input  logic         clear,
  output logic [127:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [4:0]   fill_count,
  output logic         overrun
);

  localparam int DATA_W      = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = DATA_W * BLOCK_BYTES;

  localparam logic [4:0] FILL_FULL = 5'(BLOCK_BYTES);
  localparam logic [4:0] FILL_LAST = 5'(BLOCK_BYTES - 1);

  // Byte k of a block occupies bits [127-8k -: 8]; positions outside 0..15
  // (a FULL accumulator) leave the block untouched.
  function automatic logic [BLOCK_W-1:0] insert_byte(
    input logic [BLOCK_W-1:0] blk,
    input logic [4:0]         pos,
    input logic [DATA_W-1:0]  b
  );
    logic [BLOCK_W-1:0] r;
    r = blk;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (pos == 5'(i)) begin
        r[BLOCK_W-1-DATA_W*i -: DATA_W] = b;
      end
    end
    return r;
  endfunction

  logic [BLOCK_W-1:0] acc_p0;
  logic [BLOCK_W-1:0] acc_next;
  logic               accept;
  logic               full_now;
  logic               hold_free;
  logic               consume;
  logic               xfer;

  // Handshake decode and the block as it would look after this edge's byte.
  always_comb begin
    byte_ready = (fill_count != FILL_FULL);
    accept     = byte_valid && byte_ready;
    acc_next   = accept ? insert_byte(acc_p0, fill_count, byte_in) : acc_p0;
    // Full either because it already is, or because this byte completes it.
    full_now   = (fill_count == FILL_FULL) || (accept && (fill_count == FILL_LAST));
    hold_free  = !block_valid || block_ready;
    consume    = block_valid && block_ready;
    // clear wins over a transfer: the accumulator is discarded, not forwarded.
    xfer       = !clear && full_now && hold_free;
  end

  // ---- stage 0: byte accumulator ----
  // Accumulator and fill level; emptied by clear, by a transfer, or by reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_p0     <= '0;
      fill_count <= '0;
    end else if (clear || xfer) begin
      acc_p0     <= '0;
      fill_count <= '0;
    end else if (accept) begin
      acc_p0     <= acc_next;
      fill_count <= fill_count + 5'd1;
    end
  end

  // ---- stage 1: holding register ----
  // Holding register; a same-edge consume and transfer keeps block_valid high.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      block_out   <= '0;
      block_valid <= 1'b0;
    end else if (xfer) begin
      block_out   <= acc_next;
      block_valid <= 1'b1;
    end else if (consume) begin
      block_valid <= 1'b0;
    end
  end

  // Dropped-byte indication, one cycle per byte refused; clear masks it.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= byte_valid && !byte_ready && !clear;
    end
  end

endmodule

// File: tb/tb_stp8to128.sv
// Bench for stp8to128: directed scenarios then random traffic, checked against
// a queue-based reference model and a scoreboard of expected blocks.
module tb_stp8to128;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         clear;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic [4:0]   fill_count;
  logic         overrun;

  stp8to128 dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .clear      (clear),
    .block_out  (block_out),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .fill_count (fill_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: the accumulator is a plain byte queue, the holding
  // register a valid flag plus data, finished blocks go to the scoreboard.
  logic [7:0]   m_acc[$];
  logic         m_hv;
  logic [127:0] m_hd;
  logic         m_ovr;
  logic [127:0] exp_q[$];
  bit           started = 0;

  function automatic logic [127:0] pack(input logic [7:0] q[$]);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], q[i]};
    return r;
  endfunction

  always @(posedge clk) begin
    bit rdy;
    rdy = (m_acc.size() != 16);
    started = 1;
    if (!n_rst) begin
      m_acc.delete();
      m_hv = 0;
      m_hd = '0;
      m_ovr = 0;
      exp_q.delete();
    end else begin
      m_ovr = byte_valid && !rdy && !clear;
      if (clear) m_acc.delete();
      else if (byte_valid && rdy) m_acc.push_back(byte_in);
      if (!clear && m_acc.size() == 16 && (!m_hv || block_ready)) begin
        m_hd = pack(m_acc);
        m_hv = 1;
        exp_q.push_back(m_hd);
        m_acc.delete();
      end else if (m_hv && block_ready) begin
        m_hv = 0;
      end
    end
  end

  // Monitor: compare visible state every cycle and pop the scoreboard
  // whenever the DUT presents a block that is being consumed.
  always @(negedge clk) begin
    if (started) begin
      check("fill_count", 128'(fill_count), 128'(m_acc.size()));
      check("byte_ready", 128'(byte_ready), 128'(m_acc.size() != 16));
      check("block_valid", 128'(block_valid), 128'(m_hv));
      check("block_out", block_out, m_hd);
      check("overrun", 128'(overrun), 128'(m_ovr));
      if (n_rst && block_valid && block_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_pop: got block %h, expected no block", block_out);
        end else begin
          check("sb_block", block_out, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic nr, input logic bv, input logic [7:0] b,
                      input logic clr, input logic br);
    n_rst = nr; byte_valid = bv; byte_in = b; clear = clr; block_ready = br;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with byte_valid asserted.
    step(0, 1, 8'h77, 0, 0);
    step(0, 1, 8'h77, 0, 0);
    check("rst_block_out", block_out, '0);
    check("rst_block_valid", 128'(block_valid), 128'(0));
    check("rst_fill", 128'(fill_count), 128'(0));
    check("rst_byte_ready", 128'(byte_ready), 128'(1));
    check("rst_overrun", 128'(overrun), 128'(0));

    // Basic fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) step(1, 1, 8'(i), 0, 0);
    check("basic_valid", 128'(block_valid), 128'(1));
    check("basic_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("basic_fill", 128'(fill_count), 128'(0));

    // Backpressure: accumulator fills while the block waits, then overrun.
    for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h10 + i), 0, 0);
    check("bp_fill16", 128'(fill_count), 128'(16));
    check("bp_not_ready", 128'(byte_ready), 128'(0));
    step(1, 1, 8'hFF, 0, 0);
    check("bp_overrun", 128'(overrun), 128'(1));
    step(1, 0, 8'h00, 0, 0);
    check("bp_overrun_pulse", 128'(overrun), 128'(0));
    step(1, 0, 8'h00, 0, 1);
    check("bp_block", block_out, 128'h101112131415161718191A1B1C1D1E1F);
    check("bp_valid", 128'(block_valid), 128'(1));
    check("bp_ready_back", 128'(byte_ready), 128'(1));

    // Consume and transfer on the same edge.
    for (int i = 0; i < 15; i++) step(1, 1, 8'(8'h30 + i), 0, 0);
    step(1, 1, 8'h3F, 0, 1);
    check("sim_valid", 128'(block_valid), 128'(1));
    check("sim_block", block_out, 128'h303132333435363738393A3B3C3D3E3F);
    step(1, 0, 8'h00, 0, 1);
    check("sim_drained", 128'(block_valid), 128'(0));

    // Clear mid-block.
    for (int i = 0; i < 5; i++) step(1, 1, 8'h55, 0, 0);
    step(1, 1, 8'h55, 1, 0);
    check("clr_fill", 128'(fill_count), 128'(0));
    for (int i = 0; i < 16; i++) step(1, 1, 8'(8'hA0 + i), 0, 0);
    check("clr_block", block_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);

    // Reset with a pending block and a partial accumulator.
    for (int i = 0; i < 8; i++) step(1, 1, 8'h11, 0, 0);
    check("mid_fill8", 128'(fill_count), 128'(8));
    step(0, 0, 8'h00, 0, 0);
    check("mid_rst_valid", 128'(block_valid), 128'(0));
    check("mid_rst_fill", 128'(fill_count), 128'(0));
    check("mid_rst_block", block_out, '0);
    for (int i = 0; i < 16; i++) step(1, 1, (i % 2 == 0) ? 8'hAA : 8'h55, 0, 0);
    check("alt_block", block_out, 128'hAA55AA55AA55AA55AA55AA55AA55AA55);
    step(1, 0, 8'h00, 0, 1);

    // Random traffic with varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      int pr;
      pr = (i / 500) % 3;
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 9) < 8,
           8'($urandom),
           $urandom_range(0, 59) == 0,
           (pr == 0) ? ($urandom_range(0, 9) < 9) :
           (pr == 1) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 1) == 1));
    end
    step(1, 0, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
